// File: rtl/uart_cmd_responder.sv
// UART command endpoint: pairs received bytes into 16-bit commands (with an
// inter-byte timeout) and sends single-byte responses through the UART transmitter.

module uart_cmd_responder_chk (
  input logic clk,
  input logic rst_n,
  input logic rx_rdy,
  input logic clr_rx_rdy,
  input logic complete,
  input logic cmd_rdy,
  input logic trmt,
  input logic resp_busy,
  input logic resp_sent
);

  a_clr_needs_rdy: assert property (@(posedge clk) disable iff (!rst_n) clr_rx_rdy |-> rx_rdy);
  a_complete_sets_rdy: assert property (@(posedge clk) disable iff (!rst_n) complete |=> cmd_rdy);
  a_trmt_single: assert property (@(posedge clk) disable iff (!rst_n) trmt |=> !trmt);
  a_trmt_busy: assert property (@(posedge clk) disable iff (!rst_n) trmt |-> resp_busy);
  a_sent_single: assert property (@(posedge clk) disable iff (!rst_n) resp_sent |=> !resp_sent);
  a_sent_idle: assert property (@(posedge clk) disable iff (!rst_n) resp_sent |-> !resp_busy);

endmodule

module uart_cmd_responder #(
  parameter int unsigned TIMEOUT_CLKS = 32'd52080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_busy,
  output logic        resp_sent
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CLKS - 32'd1);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    RIDLE = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } tx_state_t;

  rx_state_t   rx_state_r;
  rx_state_t   rx_next_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_next_s;
  logic [7:0]  hold_r;
  logic [15:0] cmd_r;
  logic        cmd_rdy_r;
  logic        cmd_rdy_next_s;
  logic        load_hi_s;
  logic        complete_s;
  logic        clr_rx_s;

  tx_state_t   tx_state_r;
  tx_state_t   tx_next_s;
  logic        load_tx_s;
  logic        sent_s;
  logic        first_busy_r;
  logic        trmt_r;
  logic [7:0]  tx_data_r;
  logic        resp_busy_r;
  logic        resp_sent_r;

  // Receive FSM: next state, byte consume strobe and timeout counter update.
  always_comb begin
    rx_next_s  = rx_state_r;
    cnt_next_s = cnt_r;
    load_hi_s  = 1'b0;
    complete_s = 1'b0;
    clr_rx_s   = 1'b0;
    case (rx_state_r)
      IDLE: begin
        cnt_next_s = 16'h0000;
        if (rx_rdy) begin
          clr_rx_s  = 1'b1;
          load_hi_s = 1'b1;
          rx_next_s = WAIT_LO;
        end else begin
          rx_next_s = IDLE;
        end
      end
      WAIT_LO: begin
        // A low byte on the final timeout cycle still completes the command.
        if (rx_rdy) begin
          clr_rx_s   = 1'b1;
          complete_s = 1'b1;
          cnt_next_s = 16'h0000;
          rx_next_s  = IDLE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          cnt_next_s = 16'h0000;
          rx_next_s  = IDLE;
        end else begin
          cnt_next_s = cnt_r + 16'd1;
          rx_next_s  = WAIT_LO;
        end
      end
      default: begin
        cnt_next_s = 16'h0000;
        rx_next_s  = IDLE;
      end
    endcase
  end

  // Command-ready flag: a completing command beats a simultaneous clear.
  always_comb begin
    if (complete_s) begin
      cmd_rdy_next_s = 1'b1;
    end else if (clr_cmd_rdy) begin
      cmd_rdy_next_s = 1'b0;
    end else begin
      cmd_rdy_next_s = cmd_rdy_r;
    end
  end

  // Receive-side state, counter, high-byte hold and command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r <= IDLE;
      cnt_r      <= 16'h0000;
      hold_r     <= 8'h00;
      cmd_r      <= 16'h0000;
      cmd_rdy_r  <= 1'b0;
    end else begin
      rx_state_r <= rx_next_s;
      cnt_r      <= cnt_next_s;
      cmd_rdy_r  <= cmd_rdy_next_s;
      if (load_hi_s) begin
        hold_r <= rx_data;
      end
      if (complete_s) begin
        cmd_r <= {hold_r, rx_data};
      end
    end
  end

  // Transmit FSM: next state, response capture and completion strobe.
  always_comb begin
    tx_next_s = tx_state_r;
    load_tx_s = 1'b0;
    sent_s    = 1'b0;
    case (tx_state_r)
      RIDLE: begin
        if (send_resp) begin
          load_tx_s = 1'b1;
          tx_next_s = START;
        end else begin
          tx_next_s = RIDLE;
        end
      end
      START: begin
        tx_next_s = BUSY;
      end
      BUSY: begin
        // tx_done may still be stale on the first busy cycle.
        if (!first_busy_r && tx_done) begin
          sent_s    = 1'b1;
          tx_next_s = RIDLE;
        end else begin
          tx_next_s = BUSY;
        end
      end
      default: begin
        tx_next_s = RIDLE;
      end
    endcase
  end

  // Transmit-side state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r   <= RIDLE;
      first_busy_r <= 1'b0;
      trmt_r       <= 1'b0;
      tx_data_r    <= 8'h00;
      resp_busy_r  <= 1'b0;
      resp_sent_r  <= 1'b0;
    end else begin
      tx_state_r   <= tx_next_s;
      first_busy_r <= (tx_state_r == START);
      trmt_r       <= (tx_next_s == START);
      resp_busy_r  <= (tx_next_s != RIDLE);
      resp_sent_r  <= sent_s;
      if (load_tx_s) begin
        tx_data_r <= resp;
      end
    end
  end

  assign clr_rx_rdy = clr_rx_s;
  assign cmd        = cmd_r;
  assign cmd_rdy    = cmd_rdy_r;
  assign trmt       = trmt_r;
  assign tx_data    = tx_data_r;
  assign resp_busy  = resp_busy_r;
  assign resp_sent  = resp_sent_r;

  uart_cmd_responder_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .clr_rx_rdy (clr_rx_s),
    .complete   (complete_s),
    .cmd_rdy    (cmd_rdy_r),
    .trmt       (trmt_r),
    .resp_busy  (resp_busy_r),
    .resp_sent  (resp_sent_r)
  );

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Randomized self-checking bench for uart_cmd_responder with a behavioural
// byte-pairing model and a simple UART transmitter stand-in.

module tb_uart_cmd_responder;

  localparam int T = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        resp_busy;
  logic        resp_sent;

  uart_cmd_responder #(.TIMEOUT_CLKS(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .resp        (resp),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .resp_busy   (resp_busy),
    .resp_sent   (resp_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle stamp, receive-consume counter and transmitter stand-in.
  int cyc = 0;
  int clr_cnt = 0;
  int trmt_cnt = 0;
  int sent_cnt = 0;
  int resp_sent_cnt = 0;
  int tx_left = 0;
  logic [7:0] tx_shift = 8'h00;
  logic [7:0] last_sent = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_rx_rdy) clr_cnt <= clr_cnt + 1;
    if (resp_sent) resp_sent_cnt <= resp_sent_cnt + 1;
    if (trmt) begin
      tx_done  <= 1'b0;
      tx_shift <= tx_data;
      tx_left  <= 8 + int'($urandom_range(0, 12));
      trmt_cnt <= trmt_cnt + 1;
    end else if (tx_left == 1) begin
      tx_done   <= 1'b1;
      last_sent <= tx_shift;
      sent_cnt  <= sent_cnt + 1;
      tx_left   <= 0;
    end else if (tx_left > 1) begin
      tx_left <= tx_left - 1;
    end
  end

  // Reference model: a byte completes a command when it follows a pending
  // high byte by at most T cycles; otherwise it becomes the new high byte.
  logic [15:0] exp_cmd = 16'h0000;
  logic        exp_rdy = 1'b0;
  bit          pend = 1'b0;
  logic [7:0]  phold = 8'h00;
  int          pstamp = 0;
  int          bytes_sent = 0;

  task automatic model_reset();
    exp_cmd = 16'h0000;
    exp_rdy = 1'b0;
    pend    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit clr_also);
    int stamp;
    @(negedge clk);
    rx_rdy = 1'b1;
    rx_data = b;
    clr_cmd_rdy = clr_also;
    stamp = cyc;
    #1;
    check_eq("clr_rx_rdy_on_byte", {31'd0, clr_rx_rdy}, 32'd1);
    if (pend && (stamp - pstamp) <= T) begin
      exp_cmd = {phold, b};
      exp_rdy = 1'b1;
      pend = 1'b0;
    end else begin
      if (clr_also) exp_rdy = 1'b0;
      pend = 1'b1;
      phold = b;
      pstamp = stamp;
    end
    bytes_sent++;
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
    #1;
    check_eq("clr_rx_rdy_drop", {31'd0, clr_rx_rdy}, 32'd0);
    check_eq("cmd", {16'd0, cmd}, {16'd0, exp_cmd});
    check_eq("cmd_rdy", {31'd0, cmd_rdy}, {31'd0, exp_rdy});
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
    check_eq("cmd_rdy_cleared", {31'd0, cmd_rdy}, 32'd0);
    check_eq("cmd_hold_on_clear", {16'd0, cmd}, {16'd0, exp_cmd});
  endtask

  task automatic do_resp(input logic [7:0] b, input bit poke);
    int t0, s0, r0;
    bit seen, busy_ok;
    t0 = trmt_cnt;
    s0 = sent_cnt;
    r0 = resp_sent_cnt;
    @(negedge clk);
    resp = b;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    check_eq("trmt_pulse", {31'd0, trmt}, 32'd1);
    check_eq("busy_at_start", {31'd0, resp_busy}, 32'd1);
    check_eq("tx_data_loaded", {24'd0, tx_data}, {24'd0, b});
    seen = 1'b0;
    busy_ok = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (resp_sent) begin
        seen = 1'b1;
      end else if (resp_busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
      if (poke && i == 2) begin
        resp = 8'hFF;
        send_resp = 1'b1;
      end else begin
        send_resp = 1'b0;
      end
    end
    send_resp = 1'b0;
    check_eq("resp_sent_seen", {31'd0, seen}, 32'd1);
    check_eq("busy_until_sent", {31'd0, busy_ok}, 32'd1);
    check_eq("idle_at_sent", {31'd0, resp_busy}, 32'd0);
    @(negedge clk);
    check_eq("resp_sent_width", {31'd0, resp_sent}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("trmt_count", trmt_cnt - t0, 32'd1);
    check_eq("bytes_on_line", sent_cnt - s0, 32'd1);
    check_eq("byte_on_line", {24'd0, last_sent}, {24'd0, b});
    check_eq("resp_sent_count", resp_sent_cnt - r0, 32'd1);
    check_eq("tx_data_stable", {24'd0, tx_data}, {24'd0, b});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, n;
    #1;
    check_eq("rst_cmd", {16'd0, cmd}, 32'd0);
    check_eq("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check_eq("rst_trmt", {31'd0, trmt}, 32'd0);
    check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check_eq("rst_resp_busy", {31'd0, resp_busy}, 32'd0);
    check_eq("rst_resp_sent", {31'd0, resp_sent}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic pair.
    send_byte(8'hA5, 1'b0);
    idle(10);
    send_byte(8'h3C, 1'b0);
    check_eq("pair_a53c", {16'd0, cmd}, 32'h0000A53C);

    // Timed-out high byte is discarded.
    idle(T + 2);
    send_byte(8'h12, 1'b0);
    idle(T + 5);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    check_eq("timeout_3456", {16'd0, cmd}, 32'h00003456);

    // Low byte exactly on the last allowed cycle, then one cycle late.
    idle(T + 2);
    send_byte(8'h11, 1'b0);
    idle(T - 1);
    send_byte(8'h22, 1'b0);
    check_eq("edge_in_time", {16'd0, cmd}, 32'h00001122);
    send_byte(8'h77, 1'b0);
    idle(T);
    send_byte(8'h88, 1'b0);
    check_eq("edge_late", {16'd0, cmd}, 32'h00001122);

    // Overwrite while ready, clear, then set beats clear.
    idle(T + 2);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    check_eq("overwrite_0304", {16'd0, cmd}, 32'h00000304);
    pulse_clr();
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b1);
    check_eq("set_beats_clear", {31'd0, cmd_rdy}, 32'd1);

    // Randomized byte stream around the timeout boundary.
    for (int i = 0; i < 60; i++) begin
      int g;
      case ($urandom_range(0, 4))
        0: g = T - 1;
        1: g = T;
        2: g = 0;
        default: g = int'($urandom_range(0, T + 10));
      endcase
      if ($urandom_range(0, 3) == 0) pulse_clr();
      idle(g);
      send_byte(8'($urandom), ($urandom_range(0, 7) == 0));
    end
    idle(2);
    check_eq("clr_pulse_total", clr_cnt, bytes_sent);

    // Responses.
    do_resp(8'hA5, 1'b0);
    do_resp(8'h55, 1'b1);
    for (int i = 0; i < 4; i++) do_resp(8'($urandom), 1'($urandom_range(0, 1)));

    // Level-held request re-triggers after each completion.
    t0 = trmt_cnt;
    n = 0;
    @(negedge clk);
    resp = 8'h3C;
    send_resp = 1'b1;
    for (int i = 0; i < 400 && n < 2; i++) begin
      @(negedge clk);
      if (resp_sent) begin
        n++;
        if (n == 2) send_resp = 1'b0;
      end
    end
    send_resp = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("level_sent", n, 32'd2);
    check_eq("level_trmt", trmt_cnt - t0, 32'd2);

    // Asynchronous reset during WAIT_LO and BUSY.
    idle(T + 2);
    send_byte(8'hC3, 1'b0);
    @(negedge clk);
    resp = 8'h99;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_cmd", {16'd0, cmd}, 32'd0);
    check_eq("arst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check_eq("arst_trmt", {31'd0, trmt}, 32'd0);
    check_eq("arst_tx_data", {24'd0, tx_data}, 32'd0);
    check_eq("arst_resp_busy", {31'd0, resp_busy}, 32'd0);
    check_eq("arst_resp_sent", {31'd0, resp_sent}, 32'd0);
    check_eq("arst_clr_rx_rdy", {31'd0, clr_rx_rdy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    check_eq("after_reset_beef", {16'd0, cmd}, 32'h0000BEEF);
    idle(30);
    do_resp(8'h5A, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
